// File: rtl/io_ctrl_gen.sv
// System I/O controller: input mux, control latch, coin counter drivers,
// sound command latch, vblank interrupt and cycle-counting watchdog.
`timescale 1ns/1ps
module io_ctrl_gen #(
    parameter int                   NUM_PLAYERS = 4,
    parameter int                   COIN_PULSE  = 16,
    parameter int                   COIN_GAP    = 8,
    parameter bit                   WDOG_EN     = 1'b1,
    parameter int                   WDOG_BITS   = 22,
    parameter logic [WDOG_BITS-1:0] WDOG_LIMIT  = 22'h3FFFFF,
    parameter int                   WDOG_HOLD   = 16
) (
    input  logic                     clk_main,
    input  logic                     nRESET,
    input  logic                     cs_n,
    input  logic                     rw,
    input  logic                     lds_n,
    input  logic [3:0]               addr,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     rd_ack,
    input  logic [8*NUM_PLAYERS-1:0] p_in,
    input  logic [NUM_PLAYERS-1:0]   p_coin,
    input  logic [NUM_PLAYERS-1:0]   service,
    input  logic [19:0]              dipsw,
    input  logic                     vblank_n,
    output logic                     irq_n,
    output logic                     int_en,
    output logic                     rmrd,
    output logic                     sndon,
    output logic [1:0]               coin_counter,
    output logic [7:0]               snd_code,
    output logic                     snd_strobe,
    output logic                     wdog_rst_n
);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} coin_state_t;

    localparam int                 TMAX       = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
    localparam int                 TW         = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0]      PULSE_LAST = TW'(COIN_PULSE - 1);
    localparam logic [TW-1:0]      GAP_LAST   = TW'(COIN_GAP - 1);
    localparam int                 HW         = (WDOG_HOLD > 1) ? $clog2(WDOG_HOLD) : 1;
    localparam logic [HW-1:0]      HOLD_LAST  = HW'(WDOG_HOLD - 1);
    localparam logic [WDOG_BITS-1:0] WDOG_LAST = WDOG_LIMIT - 1'b1;

    // Bus access registers
    logic       r_cs_n_d, r_rd_ack;
    logic [7:0] r_dout;
    // Control and sound latches
    logic       r_int_en, r_rmrd, r_sndon, r_snd_strobe;
    logic [1:0] r_coin_prev;
    logic [7:0] r_snd_code;
    // Interrupt path
    logic       r_vb_s1, r_vb_s2, r_vb_d, r_irq_pend;
    // Coin channels
    coin_state_t   r_cstate [2];
    coin_state_t   w_cstate_nxt [2];
    logic [3:0]    r_pend [2];
    logic [3:0]    w_pend_nxt [2];
    logic [3:0]    w_pend_eff [2];
    logic [TW-1:0] r_ctmr [2];
    logic [TW-1:0] w_ctmr_nxt [2];
    logic [1:0]    w_coin_on;
    // Watchdog
    logic [WDOG_BITS-1:0] r_wd_cnt;
    logic [HW-1:0]        r_wd_tmr;
    logic                 r_wd_hold;

    logic       w_start, w_rd, w_wr, w_wr_ctrl, w_wr_snd, w_kick, w_vb_fall;
    logic [1:0] w_coin_req;
    logic [3:0] w_coin_ext, w_serv_ext;
    logic [7:0] w_player [4];
    logic [7:0] w_rd_data;

    // An access is the first selected cycle after a deselected one
    assign w_start    = r_cs_n_d & ~cs_n;
    assign w_rd       = w_start & rw;
    assign w_wr       = w_start & ~rw & ~lds_n;
    assign w_wr_ctrl  = w_wr & (addr == 4'd0);
    assign w_wr_snd   = w_wr & (addr == 4'd1);
    assign w_kick     = w_wr & (addr == 4'd2);
    assign w_coin_req = {2{w_wr_ctrl}} & din[1:0] & ~r_coin_prev;
    assign w_vb_fall  = r_vb_d & ~r_vb_s2;

    // Read data mux; unfitted players and their coin/service bits read as 1
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_coin_ext = 4'hF;
        w_serv_ext = 4'hF;
        for (int i = 0; i < 4; i++) w_player[i] = 8'hFF;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            w_coin_ext[i] = p_coin[i];
            w_serv_ext[i] = service[i];
            w_player[i]   = p_in[8*i +: 8];
        end
        w_rd_data = 8'hFF;
        case (addr)
            4'd0:                   w_rd_data = {w_serv_ext, w_coin_ext};
            4'd1, 4'd2, 4'd3, 4'd4: w_rd_data = w_player[2'(addr - 4'd1)];
            4'd5:                   w_rd_data = dipsw[7:0];
            4'd6:                   w_rd_data = dipsw[15:8];
            4'd7:                   w_rd_data = {4'hF, dipsw[19:16]};
            default:                w_rd_data = 8'hFF;
        endcase
    end

    // Access edge detect and registered read return
    always_ff @(posedge clk_main or negedge nRESET) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!nRESET) begin
            r_cs_n_d <= 1'b1;
            r_rd_ack <= 1'b0;
            r_dout   <= 8'h00;
        end else begin
            r_cs_n_d <= cs_n;
            r_rd_ack <= w_rd;
            if (w_rd) r_dout <= w_rd_data;
        end
    end

    // Control latch, coin request history and sound command latch
    always_ff @(posedge clk_main or negedge nRESET) begin
        if (!nRESET) begin
            r_rmrd       <= 1'b0;
            r_int_en     <= 1'b0;
            r_sndon      <= 1'b0;
            r_coin_prev  <= 2'b00;
            r_snd_code   <= 8'h00;
            r_snd_strobe <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_rmrd      <= din[7];
                r_int_en    <= din[5];
                r_sndon     <= din[3];
                r_coin_prev <= din[1:0];
            end
            if (w_wr_snd) r_snd_code <= din;
            r_snd_strobe <= w_wr_snd;
        end
    end

    // Vblank synchroniser and interrupt pending flag (cleared while disabled)
    always_ff @(posedge clk_main or negedge nRESET) begin
        if (!nRESET) begin
            r_vb_s1    <= 1'b1;
            r_vb_s2    <= 1'b1;
            r_vb_d     <= 1'b1;
            r_irq_pend <= 1'b0;
        end else begin
            r_vb_s1    <= vblank_n;
            r_vb_s2    <= r_vb_s1;
            r_vb_d     <= r_vb_s2;
            r_irq_pend <= r_int_en & (r_irq_pend | w_vb_fall);
        end
    end

    // Coin channel next state: queue requests, serve one pulse per IDLE/GAP-end check
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            w_pend_eff[c]   = (r_pend[c] == 4'hF) ? 4'hF : r_pend[c] + {3'b000, w_coin_req[c]};
            w_cstate_nxt[c] = r_cstate[c];
            w_pend_nxt[c]   = w_pend_eff[c];
            w_ctmr_nxt[c]   = r_ctmr[c];
            w_coin_on[c]    = (r_cstate[c] == S_ON);
            case (r_cstate[c])
                S_IDLE: begin
                    if (w_pend_eff[c] != 4'd0) begin
                        w_cstate_nxt[c] = S_ON;
                        w_pend_nxt[c]   = w_pend_eff[c] - 4'd1;
                        w_ctmr_nxt[c]   = PULSE_LAST;
                    end
                end
                S_ON: begin
                    if (r_ctmr[c] == '0) begin
                        w_cstate_nxt[c] = S_GAP;
                        w_ctmr_nxt[c]   = GAP_LAST;
                    end else begin
                        w_ctmr_nxt[c] = r_ctmr[c] - 1'b1;
                    end
                end
                S_GAP: begin
                    // Last gap cycle doubles as the idle check so queued pulses are COIN_GAP apart
                    if (r_ctmr[c] != '0) begin
                        w_ctmr_nxt[c] = r_ctmr[c] - 1'b1;
                    end else if (w_pend_eff[c] != 4'd0) begin
                        w_cstate_nxt[c] = S_ON;
                        w_pend_nxt[c]   = w_pend_eff[c] - 4'd1;
                        w_ctmr_nxt[c]   = PULSE_LAST;
                    end else begin
                        w_cstate_nxt[c] = S_IDLE;
                    end
                end
                default: w_cstate_nxt[c] = S_IDLE;
            endcase
        end
    end

    // Coin channel state registers
    always_ff @(posedge clk_main or negedge nRESET) begin
        if (!nRESET) begin
            for (int c = 0; c < 2; c++) begin
                r_cstate[c] <= S_IDLE;
                r_pend[c]   <= 4'd0;
                r_ctmr[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                r_cstate[c] <= w_cstate_nxt[c];
                r_pend[c]   <= w_pend_nxt[c];
                r_ctmr[c]   <= w_ctmr_nxt[c];
            end
        end
    end

    // Watchdog: count, fire at the limit, hold reset low, then restart from zero
    always_ff @(posedge clk_main or negedge nRESET) begin
        if (!nRESET) begin
            r_wd_cnt  <= '0;
            r_wd_tmr  <= '0;
            r_wd_hold <= 1'b0;
        end else if (WDOG_EN) begin
            if (r_wd_hold) begin
                if (r_wd_tmr == '0) begin
                    r_wd_hold <= 1'b0;
                    r_wd_cnt  <= '0;
                end else begin
                    r_wd_tmr <= r_wd_tmr - 1'b1;
                end
            end else if (w_kick) begin
                r_wd_cnt <= '0;
            end else if (r_wd_cnt == WDOG_LAST) begin
                r_wd_hold <= 1'b1;
                r_wd_tmr  <= HOLD_LAST;
            end else begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
        end
    end

    assign dout         = r_dout;
    assign rd_ack       = r_rd_ack;
    assign int_en       = r_int_en;
    assign rmrd         = r_rmrd;
    assign sndon        = r_sndon;
    // Gating with the live enable drops the request in the same cycle int_en clears
    assign irq_n        = ~(r_irq_pend & r_int_en);
    assign coin_counter = w_coin_on;
    assign snd_code     = r_snd_code;
    assign snd_strobe   = r_snd_strobe;
    assign wdog_rst_n   = ~r_wd_hold;

endmodule

// File: tb/tb_io_ctrl_gen.sv
// Directed self-checking bench for io_ctrl_gen (2 players, short coin and watchdog timings).
`timescale 1ns/1ps
module tb_io_ctrl_gen;

    logic        clk_main = 1'b0;
    logic        nRESET, cs_n, rw, lds_n, vblank_n;
    logic [3:0]  addr;
    logic [7:0]  din, dout, snd_code;
    logic        rd_ack, irq_n, int_en, rmrd, sndon, snd_strobe, wdog_rst_n;
    logic [15:0] p_in;
    logic [1:0]  p_coin, service, coin_counter;
    logic [19:0] dipsw;

    int errors = 0;
    int checks = 0;
    int n, low, npulse, run;
    int hi_len [4];
    int gap_len [4];
    logic [39:0] h0, h1;
    logic seen;

    always #5 clk_main = ~clk_main;

    io_ctrl_gen #(
        .NUM_PLAYERS(2), .COIN_PULSE(4), .COIN_GAP(2), .WDOG_EN(1'b1),
        .WDOG_BITS(22), .WDOG_LIMIT(22'd100), .WDOG_HOLD(16)
    ) dut (
        .clk_main(clk_main), .nRESET(nRESET), .cs_n(cs_n), .rw(rw), .lds_n(lds_n),
        .addr(addr), .din(din), .dout(dout), .rd_ack(rd_ack), .p_in(p_in),
        .p_coin(p_coin), .service(service), .dipsw(dipsw), .vblank_n(vblank_n),
        .irq_n(irq_n), .int_en(int_en), .rmrd(rmrd), .sndon(sndon),
        .coin_counter(coin_counter), .snd_code(snd_code), .snd_strobe(snd_strobe),
        .wdog_rst_n(wdog_rst_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [7:0] exp, input string tag);
        @(negedge clk_main); cs_n = 1'b0; rw = 1'b1; addr = a;
        @(negedge clk_main);
        check({tag, "_ack"}, {31'd0, rd_ack}, 32'd1);
        check(tag, {24'd0, dout}, {24'd0, exp});
        cs_n = 1'b1;
        @(negedge clk_main);
        check({tag, "_ack_end"}, {31'd0, rd_ack}, 32'd0);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d, input logic l);
        @(negedge clk_main); cs_n = 1'b0; rw = 1'b0; lds_n = l; addr = a; din = d;
        @(negedge clk_main); cs_n = 1'b1; rw = 1'b1; lds_n = 1'b1;
    endtask

    initial begin
        nRESET = 1'b0; cs_n = 1'b1; rw = 1'b1; lds_n = 1'b1; addr = 4'd0; din = 8'h00;
        p_in = 16'hFEFF; p_coin = 2'b11; service = 2'b11;
        dipsw = {4'h5, 8'h3C, 8'hA1}; vblank_n = 1'b1;
        repeat (3) @(negedge clk_main);

        // Reset state
        check("rst_dout", {24'd0, dout}, 32'h0);
        check("rst_rd_ack", {31'd0, rd_ack}, 32'd0);
        check("rst_irq_n", {31'd0, irq_n}, 32'd1);
        check("rst_latches", {29'd0, int_en, rmrd, sndon}, 32'd0);
        check("rst_coin", {30'd0, coin_counter}, 32'd0);
        check("rst_snd", {23'd0, snd_strobe, snd_code}, 32'd0);
        check("rst_wdog", {31'd0, wdog_rst_n}, 32'd1);
        nRESET = 1'b1;

        // Input reads
        bus_read(4'd2, 8'hFE, "rd_p1");
        bus_read(4'd1, 8'hFF, "rd_p0");
        bus_read(4'd3, 8'hFF, "rd_p2_absent");
        bus_read(4'd4, 8'hFF, "rd_p3_absent");
        bus_read(4'd0, 8'hFF, "rd_sys_idle");
        bus_read(4'd5, 8'hA1, "rd_dip1");
        bus_read(4'd6, 8'h3C, "rd_dip2");
        bus_read(4'd7, 8'hF5, "rd_dip3");
        bus_read(4'd9, 8'hFF, "rd_unmapped");
        p_coin = 2'b01; service = 2'b10;
        bus_read(4'd0, 8'hED, "rd_sys_active");
        p_coin = 2'b11; service = 2'b11;

        // Sound latch and strobe
        bus_write(4'd1, 8'h5A, 1'b0);
        check("snd_code", {24'd0, snd_code}, 32'h5A);
        check("snd_strobe_on", {31'd0, snd_strobe}, 32'd1);
        @(negedge clk_main);
        check("snd_strobe_off", {31'd0, snd_strobe}, 32'd0);
        bus_write(4'd1, 8'h33, 1'b1);
        check("snd_lds_hi_code", {24'd0, snd_code}, 32'h5A);
        check("snd_lds_hi_strobe", {31'd0, snd_strobe}, 32'd0);
        @(negedge clk_main); cs_n = 1'b0; rw = 1'b0; lds_n = 1'b0; addr = 4'd1; din = 8'hC3;
        n = 0;
        repeat (10) begin @(negedge clk_main); n += int'(snd_strobe); end
        cs_n = 1'b1; rw = 1'b1; lds_n = 1'b1;
        @(negedge clk_main); n += int'(snd_strobe);
        check("snd_hold_single_strobe", n, 32'd1);
        check("snd_hold_code", {24'd0, snd_code}, 32'hC3);
        @(negedge clk_main); cs_n = 1'b0; rw = 1'b1; addr = 4'd2;
        n = 0;
        repeat (10) begin @(negedge clk_main); n += int'(rd_ack); end
        cs_n = 1'b1;
        @(negedge clk_main); n += int'(rd_ack);
        check("rd_hold_single_ack", n, 32'd1);
        check("rd_hold_dout", {24'd0, dout}, 32'hFE);

        // Coin pulses: three requests close together
        h0 = '0; h1 = '0;
        fork
            begin
                bus_write(4'd0, 8'h01, 1'b0); bus_write(4'd0, 8'h00, 1'b0);
                bus_write(4'd0, 8'h01, 1'b0); bus_write(4'd0, 8'h00, 1'b0);
                bus_write(4'd0, 8'h01, 1'b0);
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk_main);
                    h0[i] = coin_counter[0];
                    h1[i] = coin_counter[1];
                end
            end
        join
        npulse = 0; run = 0;
        for (int k = 0; k < 4; k++) begin hi_len[k] = 0; gap_len[k] = 0; end
        for (int i = 0; i < 40; i++) begin
            if (h0[i]) begin
                if (i == 0 || !h0[i-1]) begin
                    if (npulse > 0 && npulse <= 4) gap_len[npulse-1] = run;
                    npulse++;
                    run = 0;
                end
                run++;
                if (npulse <= 4) hi_len[npulse-1] = run;
            end else begin
                if (i > 0 && h0[i-1]) run = 0;
                run++;
            end
        end
        check("coin_pulse_count", npulse, 32'd3);
        check("coin_hi0", hi_len[0], 32'd4);
        check("coin_hi1", hi_len[1], 32'd4);
        check("coin_hi2", hi_len[2], 32'd4);
        check("coin_gap0", gap_len[0], 32'd2);
        check("coin_gap1", gap_len[1], 32'd2);
        check("coin1_idle", {8'd0, h1[39:16]}, 32'd0);
        check("coin1_idle_lo", {16'd0, h1[15:0]}, 32'd0);

        // Control latch and interrupt
        bus_write(4'd0, 8'hA8, 1'b0);
        check("ctrl_bits", {29'd0, rmrd, int_en, sndon}, 32'd7);
        check("irq_idle", {31'd0, irq_n}, 32'd1);
        vblank_n = 1'b0; seen = 1'b0;
        repeat (3) begin @(negedge clk_main); if (irq_n === 1'b0) seen = 1'b1; end
        check("irq_within_3", {31'd0, seen}, 32'd1);
        vblank_n = 1'b1;
        repeat (4) @(negedge clk_main);
        check("irq_held", {31'd0, irq_n}, 32'd0);
        bus_write(4'd0, 8'h88, 1'b0);
        check("irq_off_int_en", {31'd0, int_en}, 32'd0);
        check("irq_off_same_cycle", {31'd0, irq_n}, 32'd1);
        check("ctrl_bits_88", {30'd0, rmrd, sndon}, 32'd3);
        vblank_n = 1'b0;
        repeat (6) @(negedge clk_main);
        check("irq_masked_edge", {31'd0, irq_n}, 32'd1);
        vblank_n = 1'b1;
        repeat (4) @(negedge clk_main);
        bus_write(4'd0, 8'hA8, 1'b0);
        repeat (2) @(negedge clk_main);
        check("irq_edge_lost", {31'd0, irq_n}, 32'd1);

        // Watchdog timing from a fresh reset
        @(negedge clk_main); nRESET = 1'b0;
        @(negedge clk_main); nRESET = 1'b1;
        n = 0;
        while (n < 300) begin
            @(negedge clk_main); n++;
            if (wdog_rst_n === 1'b0) break;
        end
        check("wdog_first_fire", n, 32'd100);
        n = 0;
        while (wdog_rst_n === 1'b0 && n < 300) begin n++; @(negedge clk_main); end
        check("wdog_hold_len", n, 32'd16);
        n = 0;
        while (wdog_rst_n === 1'b1 && n < 300) begin n++; @(negedge clk_main); end
        check("wdog_refire", n, 32'd100);
        low = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_main);
            cs_n = (i != 2); rw = (i != 2); lds_n = (i != 2); addr = 4'd2; din = 8'h00;
            if (wdog_rst_n === 1'b0) low++;
        end
        cs_n = 1'b1; rw = 1'b1; lds_n = 1'b1;
        check("wdog_hold_kick_ignored", low, 32'd16);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus_write(4'd2, 8'h00, 1'b0);
            repeat (48) begin @(negedge clk_main); if (wdog_rst_n === 1'b0) seen = 1'b1; end
        end
        check("wdog_kicked_never_fires", {31'd0, seen}, 32'd0);

        // Reset in the middle of queued coin pulses with an interrupt pending
        bus_write(4'd0, 8'hA8, 1'b0);
        vblank_n = 1'b0;
        repeat (4) @(negedge clk_main);
        vblank_n = 1'b1;
        check("pre_rst_irq", {31'd0, irq_n}, 32'd0);
        for (int k = 0; k < 18; k++) begin
            bus_write(4'd0, 8'hA9, 1'b0);
            bus_write(4'd0, 8'hA8, 1'b0);
        end
        n = 0;
        while (coin_counter[0] !== 1'b1 && n < 50) begin @(negedge clk_main); n++; end
        check("pre_rst_coin_on", {31'd0, coin_counter[0]}, 32'd1);
        #2 nRESET = 1'b0;
        #1;
        check("async_rst_coin", {30'd0, coin_counter}, 32'd0);
        check("async_rst_irq_n", {31'd0, irq_n}, 32'd1);
        check("async_rst_latches", {29'd0, int_en, rmrd, sndon}, 32'd0);
        check("async_rst_snd", {23'd0, snd_strobe, snd_code}, 32'd0);
        check("async_rst_dout", {23'd0, rd_ack, dout}, 32'd0);
        check("async_rst_wdog", {31'd0, wdog_rst_n}, 32'd1);
        @(negedge clk_main);
        @(negedge clk_main); nRESET = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk_main);
            if (coin_counter !== 2'b00 || irq_n !== 1'b1) seen = 1'b1;
        end
        check("post_rst_quiet", {31'd0, seen}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
